mem_bus_arbiter: RTL and testbench

- Round-robin arbiter sharing the single data-memory bus among N_CORES processor cores.
- Sequences each access: grant, memory-enable for MEM_LAT cycles, one-cycle ACK, then release.
- Drives SEL for the bus mux so only the granted core's address/data reach memory. The register-file BOUT tri-state discipline is thereby preserved at core level: one driver per bus.

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter_rr_pick.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the data-memory bus arbiter and its round-robin picker.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam int DEF_N_CORES = 4;
    localparam int DEF_MEM_LAT = 2;
    // Wide enough for the largest supported MEM_LAT (15).
    localparam int CNT_W       = 4;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    int cand;

    // Scan from the farthest offset down so the closest requester to ptr wins last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared data-memory bus: grant, MEM_LAT enable cycles, ACK pulse.
// Define MEM_BUS_ARBITER_LOCK_EN to add the LOCK input for back-to-back atomic accesses.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter  int N_CORES = DEF_N_CORES,
    parameter  int MEM_LAT = DEF_MEM_LAT,
    localparam int SEL_W   = sel_width(N_CORES)
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [N_CORES-1:0] REQ,
    input  logic [N_CORES-1:0] WE_REQ,
`ifdef MEM_BUS_ARBITER_LOCK_EN
    input  logic [N_CORES-1:0] LOCK,
`endif
    output logic [N_CORES-1:0] GNT,
    output logic [N_CORES-1:0] ACK,
    output logic [SEL_W-1:0]   SEL,
    output logic               MEM_EN,
    output logic               MEM_WR,
    output logic               BUSY
);

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_CORES-1:0] gnt_q, gnt_d;
    logic [N_CORES-1:0] ack_q, ack_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_wr_q, mem_wr_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic               lock_hold;
    logic [N_CORES-1:0] idx_oh;

    rr_pick #(
        .N_REQ (N_CORES),
        .IDX_W (SEL_W)
    ) u_rr_pick (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef MEM_BUS_ARBITER_LOCK_EN
    assign lock_hold = LOCK[idx_q] & REQ[idx_q];
`else
    assign lock_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            sel_q    <= '0;
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            sel_q    <= sel_d;
            mem_en_q <= mem_en_d;
            mem_wr_q <= mem_wr_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    idx_d   = pick_idx;
                    we_d    = WE_REQ[pick_idx];
                    cnt_d   = '0;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // A locked core keeps the bus and its priority position.
                if (lock_hold) begin
                    state_d = ACCESS;
                    we_d    = WE_REQ[idx_q];
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    ptr_d   = (idx_q == SEL_W'(N_CORES - 1)) ? '0 : idx_q + SEL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_idx_oh
        assign idx_oh[gi] = (idx_d == SEL_W'(gi));
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        gnt_d    = (state_d == ACCESS) ? idx_oh : '0;
        ack_d    = (state_d == DONE)   ? idx_oh : '0;
        sel_d    = idx_d;
        mem_en_d = (state_d == ACCESS);
        mem_wr_d = (state_d == ACCESS) && we_d;
        busy_d   = (state_d != IDLE);
    end

    assign GNT    = gnt_q;
    assign ACK    = ack_q;
    assign SEL    = sel_q;
    assign MEM_EN = mem_en_q;
    assign MEM_WR = mem_wr_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter (N_CORES=4, MEM_LAT=2); lock scenario under MEM_BUS_ARBITER_LOCK_EN.
module tb_mem_bus_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;

    typedef struct packed {
        logic [1:0] idx;
        logic       we;
    } exp_t;

    logic         clk = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] REQ = '0;
    logic [N-1:0] WE_REQ = '0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
    logic [N-1:0] LOCK = '0;
`endif
    logic [N-1:0] GNT;
    logic [N-1:0] ACK;
    logic [1:0]   SEL;
    logic         MEM_EN;
    logic         MEM_WR;
    logic         BUSY;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    mem_bus_arbiter #(
        .N_CORES (N),
        .MEM_LAT (LAT)
    ) dut (
        .clk    (clk),
        .RST    (RST),
        .REQ    (REQ),
        .WE_REQ (WE_REQ),
`ifdef MEM_BUS_ARBITER_LOCK_EN
        .LOCK   (LOCK),
`endif
        .GNT    (GNT),
        .ACK    (ACK),
        .SEL    (SEL),
        .MEM_EN (MEM_EN),
        .MEM_WR (MEM_WR),
        .BUSY   (BUSY)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit onehot0(input logic [N-1:0] v);
        return (v & (v - 1'b1)) == '0;
    endfunction

    function automatic logic [N-1:0] oh(input logic [1:0] i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic reset_dut();
        RST = 1'b1;
        REQ = '0;
        WE_REQ = '0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
        LOCK = '0;
`endif
        exp_q.delete();
        step();
        step();
        RST = 1'b0;
    endtask

    // Observe n complete accesses, popping the expected core/WE at each new grant.
    task automatic run(input int n, input bit auto_drop, input string tag);
        int           grants = 0;
        int           acks = 0;
        int           dur = 0;
        int           budget = 0;
        logic [N-1:0] cur_gnt = '0;
        logic         cur_we = 1'b0;
        exp_t         e;
        while ((grants < n || acks < n) && budget < 200) begin
            step();
            budget++;
            tests++;
            if ((GNT != '0 && ACK != '0) || !onehot0(GNT) || !onehot0(ACK)) begin
                fails++;
                $display("FAIL %s onehot: GNT=%b ACK=%b, required one-hot and exclusive", tag, GNT, ACK);
            end
            if (GNT != '0 && cur_gnt == '0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s grant: GNT=%b, required no grant", tag, GNT);
                    e = '0;
                end else begin
                    e = exp_q.pop_front();
                    if (GNT !== oh(e.idx) || SEL !== e.idx || MEM_WR !== e.we) begin
                        fails++;
                        $display("FAIL %s grant: GNT=%b SEL=%0d WR=%b, required GNT=%b SEL=%0d WR=%b",
                                 tag, GNT, SEL, MEM_WR, oh(e.idx), e.idx, e.we);
                    end
                end
                cur_gnt = GNT;
                cur_we  = e.we;
                dur     = 0;
                grants++;
                if (grants == n) REQ = '0;
            end
            if (cur_gnt != '0) begin
                if (GNT == cur_gnt) begin
                    dur++;
                    tests++;
                    if (MEM_EN !== 1'b1 || MEM_WR !== cur_we || BUSY !== 1'b1) begin
                        fails++;
                        $display("FAIL %s access: EN=%b WR=%b BUSY=%b, required EN=1 WR=%b BUSY=1",
                                 tag, MEM_EN, MEM_WR, BUSY, cur_we);
                    end
                end else begin
                    tests++;
                    if (dur != LAT || ACK !== cur_gnt || GNT !== '0 || MEM_EN !== 1'b0 || BUSY !== 1'b1) begin
                        fails++;
                        $display("FAIL %s ack: len=%0d ACK=%b GNT=%b EN=%b BUSY=%b, required len=%0d ACK=%b GNT=0 EN=0 BUSY=1",
                                 tag, dur, ACK, GNT, MEM_EN, BUSY, LAT, cur_gnt);
                    end
                    acks++;
                    if (auto_drop) REQ = REQ & ~cur_gnt;
                    cur_gnt = '0;
                end
            end
        end
        tests++;
        if (budget >= 200 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s timeout: grants=%0d acks=%0d left=%0d, required %0d/%0d/0",
                     tag, grants, acks, exp_q.size(), n, n);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        REQ = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (GNT !== '0 || ACK !== '0 || SEL !== '0 || MEM_EN !== 1'b0 || MEM_WR !== 1'b0 || BUSY !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: GNT=%b ACK=%b SEL=%0d EN=%b WR=%b BUSY=%b, required all 0",
                         GNT, ACK, SEL, MEM_EN, MEM_WR, BUSY);
            end
        end
        RST = 1'b0;
        step();
        tests++;
        if (GNT !== 4'b0001 || SEL !== 2'd0 || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_grant: GNT=%b SEL=%0d BUSY=%b, required 0001 0 1", GNT, SEL, BUSY);
        end
        REQ = '0;
        for (int i = 0; i < LAT; i++) step();
        tests++;
        if (ACK !== 4'b0001 || GNT !== '0) begin
            fails++;
            $display("FAIL reset_first_ack: ACK=%b GNT=%b, required 0001 0000", ACK, GNT);
        end
        step();
        tests++;
        if (BUSY !== 1'b0 || ACK !== '0) begin
            fails++;
            $display("FAIL reset_idle: BUSY=%b ACK=%b, required 0 0000", BUSY, ACK);
        end
    endtask

    task automatic test_single_write();
        reset_dut();
        REQ = 4'b0100;
        WE_REQ = 4'b0100;
        exp_q.push_back('{idx: 2'd2, we: 1'b1});
        run(1, 1'b1, "single_write");
        step();
        tests++;
        if (BUSY !== 1'b0 || MEM_EN !== 1'b0 || ACK !== '0) begin
            fails++;
            $display("FAIL single_write_idle: BUSY=%b EN=%b ACK=%b, required 0 0 0000", BUSY, MEM_EN, ACK);
        end
    endtask

    task automatic test_rotation();
        reset_dut();
        REQ = 4'b1111;
        WE_REQ = 4'b1010;
        exp_q.push_back('{idx: 2'd0, we: 1'b0});
        exp_q.push_back('{idx: 2'd1, we: 1'b1});
        exp_q.push_back('{idx: 2'd2, we: 1'b0});
        exp_q.push_back('{idx: 2'd3, we: 1'b1});
        exp_q.push_back('{idx: 2'd0, we: 1'b0});
        run(5, 1'b0, "rotation");
    endtask

    task automatic test_wrap_skip();
        reset_dut();
        REQ = 4'b0100;
        exp_q.push_back('{idx: 2'd2, we: 1'b0});
        run(1, 1'b1, "wrap_first");
        REQ = 4'b0011;
        WE_REQ = 4'b0001;
        exp_q.push_back('{idx: 2'd0, we: 1'b1});
        exp_q.push_back('{idx: 2'd1, we: 1'b0});
        run(2, 1'b1, "wrap_skip");
    endtask

    task automatic test_req_drop();
        reset_dut();
        REQ = 4'b0010;
        WE_REQ = 4'b0010;
        exp_q.push_back('{idx: 2'd1, we: 1'b1});
        run(1, 1'b0, "req_drop");
    endtask

    task automatic test_rst_mid_access();
        int           waited = 0;
        logic [N-1:0] ack_seen = '0;
        reset_dut();
        REQ = 4'b0010;
        exp_q.push_back('{idx: 2'd1, we: 1'b0});
        run(1, 1'b1, "abort_setup");
        REQ = 4'b1000;
        while (GNT == '0 && waited < 10) begin
            step();
            waited++;
        end
        tests++;
        if (GNT !== 4'b1000) begin
            fails++;
            $display("FAIL abort_grant: GNT=%b, required 1000", GNT);
        end
        step();
        RST = 1'b1;
        step();
        tests++;
        if (GNT !== '0 || MEM_EN !== 1'b0 || ACK !== '0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL abort_clear: GNT=%b EN=%b ACK=%b BUSY=%b, required all 0", GNT, MEM_EN, ACK, BUSY);
        end
        RST = 1'b0;
        REQ = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            ack_seen = ack_seen | ACK;
        end
        tests++;
        if (ack_seen !== '0) begin
            fails++;
            $display("FAIL abort_no_ack: ACK=%b, required 0000", ack_seen);
        end
        // ptr must be back at 0, so core 0 wins over core 2.
        REQ = 4'b1111;
        exp_q.push_back('{idx: 2'd0, we: 1'b0});
        run(1, 1'b0, "abort_ptr");
    endtask

`ifdef MEM_BUS_ARBITER_LOCK_EN
    task automatic test_lock();
        int           grants = 0;
        int           acks = 0;
        int           budget = 0;
        int           last_ack = 0;
        int           gap_req;
        logic [N-1:0] prev_gnt = '0;
        exp_t         e;
        reset_dut();
        LOCK = 4'b0100;
        REQ = 4'b0100;
        WE_REQ = 4'b0100;
        exp_q.push_back('{idx: 2'd2, we: 1'b1});
        exp_q.push_back('{idx: 2'd2, we: 1'b0});
        exp_q.push_back('{idx: 2'd2, we: 1'b0});
        exp_q.push_back('{idx: 2'd0, we: 1'b0});
        while (acks < 4 && budget < 100) begin
            step();
            budget++;
            if (GNT != '0 && prev_gnt == '0) begin
                grants++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                gap_req = (grants == 4) ? 1 : 0;
                tests++;
                if (GNT !== oh(e.idx) || MEM_WR !== e.we || (grants > 1 && budget - last_ack - 1 != gap_req)) begin
                    fails++;
                    $display("FAIL lock_grant%0d: GNT=%b WR=%b gap=%0d, required GNT=%b WR=%b gap=%0d",
                             grants, GNT, MEM_WR, budget - last_ack - 1, oh(e.idx), e.we, gap_req);
                end
                if (grants == 1) begin
                    REQ = 4'b0101;
                    WE_REQ = 4'b0000;
                end
                if (grants == 3) LOCK = '0;
                if (grants == 4) REQ = '0;
            end
            if (ACK != '0) begin
                acks++;
                last_ack = budget;
                if (acks == 3) REQ = 4'b0001;
            end
            prev_gnt = GNT;
        end
        tests++;
        if (budget >= 100 || grants != 4) begin
            fails++;
            $display("FAIL lock_timeout: grants=%0d acks=%0d, required 4/4", grants, acks);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_rotation();
        test_wrap_skip();
        test_req_drop();
        test_rst_mid_access();
`ifdef MEM_BUS_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
